// File: rtl/mux_pkg.sv
// Shared constants and occupancy encoding for the lane-to-byte merger.
// Optional feature macro: LANE_VALID_CHECK_EN (sticky lane-valid mismatch flag).
package mux_pkg;

    localparam int LANES     = 4;
    localparam int IDX_W     = 2;
    localparam int BUF_DEPTH = 2;

    localparam logic [LANES-1:0] ALL_VALID = 4'b1111;

    typedef enum logic [1:0] {
        EMPTY = 2'd0,
        ONE   = 2'd1,
        FULL  = 2'd2
    } occ_t;

endpackage

// File: rtl/mux_word_fifo.sv
// Two-entry word buffer holding complete 4-lane words.
// Occupancy is tracked as an EMPTY/ONE/FULL state machine.
module mux_word_fifo
    import mux_pkg::*;
#(
    parameter int DATA_W = 8
) (
    input  logic                    clk,
    input  logic                    reset,
    input  logic                    push,
    input  logic [LANES*DATA_W-1:0] wdata,
    input  logic                    pop,
    output logic [LANES*DATA_W-1:0] rdata,
    output logic [1:0]              count,
    output logic                    full,
    output logic                    empty
);

    localparam int WORD_W = LANES * DATA_W;

    occ_t        state;
    occ_t        state_nx;
    logic        wr_ptr;
    logic        rd_ptr;
    logic        do_push;
    logic        do_pop;
    logic [WORD_W-1:0] mem [BUF_DEPTH];

    assign do_push = push && (state != FULL);
    assign do_pop  = pop && (state != EMPTY);

    // Occupancy state register.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state <= EMPTY;
        end else begin
            state <= state_nx;
        end
    end

    // Next occupancy from push / word-pop.
    always_comb begin
        state_nx = state;
        unique case (state)
            EMPTY: if (do_push) state_nx = ONE;
            ONE: begin
                if (do_push && !do_pop) state_nx = FULL;
                else if (do_pop && !do_push) state_nx = EMPTY;
            end
            FULL: if (do_pop) state_nx = ONE;
            default: state_nx = EMPTY;
        endcase
    end

    // Occupancy-derived status outputs.
    always_comb begin
        count = state;
        full  = (state == FULL);
        empty = (state == EMPTY);
    end

    // Storage and pointers; both pointers may advance in one edge.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            wr_ptr <= 1'b0;
            rd_ptr <= 1'b0;
            mem[0] <= '0;
            mem[1] <= '0;
        end else begin
            if (do_push) begin
                mem[wr_ptr] <= wdata;
                wr_ptr      <= ~wr_ptr;
            end
            if (do_pop) begin
                rd_ptr <= ~rd_ptr;
            end
        end
    end

    assign rdata = mem[rd_ptr];

endmodule

// File: rtl/mux4to1_byte.sv
// Merges a 4-lane word into a byte stream, lane 0 first.
// Optional feature macro: LANE_VALID_CHECK_EN (sticky lane_err on partial valid).
module mux4to1_byte
    import mux_pkg::*;
#(
    parameter int DATA_W = 8
) (
    input  logic              clk,
    input  logic              reset,
    input  logic [DATA_W-1:0] lane0_in,
    input  logic [DATA_W-1:0] lane1_in,
    input  logic [DATA_W-1:0] lane2_in,
    input  logic [DATA_W-1:0] lane3_in,
    input  logic [LANES-1:0]  valid_in,
    output logic              ready_out,
    output logic [DATA_W-1:0] data_out,
    output logic              valid_out,
    input  logic              ready_in,
    output logic              lane_err
);

    logic [LANES*DATA_W-1:0] head;
    logic [1:0]              count;
    logic                    full;
    logic                    empty;
    logic [IDX_W-1:0]        idx;
    logic                    all_v;
    logic                    push;
    logic                    byte_pop;
    logic                    word_pop;

    assign all_v     = (valid_in == ALL_VALID);
    assign ready_out = ~full;
    assign valid_out = (count != 2'd0);
    assign push      = all_v && ready_out;
    assign byte_pop  = valid_out && ready_in;
    assign word_pop  = byte_pop && (idx == 2'd3);

    mux_word_fifo #(
        .DATA_W (DATA_W)
    ) u_fifo (
        .clk   (clk),
        .reset (reset),
        .push  (push),
        .wdata ({lane3_in, lane2_in, lane1_in, lane0_in}),
        .pop   (word_pop),
        .rdata (head),
        .count (count),
        .full  (full),
        .empty (empty)
    );

    // Byte index within the head word; wraps after lane 3.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            idx <= '0;
        end else if (byte_pop) begin
            idx <= idx + 2'd1;
        end
    end

    // Select the current lane of the head word, zero when empty.
    always_comb begin
        data_out = '0;
        if (!empty) begin
            unique case (idx)
                2'd0: data_out = head[0*DATA_W +: DATA_W];
                2'd1: data_out = head[1*DATA_W +: DATA_W];
                2'd2: data_out = head[2*DATA_W +: DATA_W];
                2'd3: data_out = head[3*DATA_W +: DATA_W];
                default: data_out = '0;
            endcase
        end
    end

`ifdef LANE_VALID_CHECK_EN
    // Sticky flag for any edge seeing a partially valid word.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            lane_err <= 1'b0;
        end else if ((valid_in != '0) && !all_v) begin
            lane_err <= 1'b1;
        end
    end
`else
    assign lane_err = 1'b0;
`endif

endmodule

// File: tb/tb_mux4to1_byte.sv
// Directed scoreboard bench for mux4to1_byte.
// Expected bytes are queued on accepted pushes and popped on transfers.
module tb_mux4to1_byte;

    logic       clk = 1'b0;
    logic       reset = 1'b0;
    logic [7:0] lane0_in = '0;
    logic [7:0] lane1_in = '0;
    logic [7:0] lane2_in = '0;
    logic [7:0] lane3_in = '0;
    logic [3:0] valid_in = '0;
    logic       ready_out;
    logic [7:0] data_out;
    logic       valid_out;
    logic       ready_in = 1'b0;
    logic       lane_err;

    int checks = 0;
    int failures = 0;

    logic [7:0] sb[$];
    int  mcount = 0;
    int  midx = 0;
    logic merr = 1'b0;
    logic [7:0] held;

    mux4to1_byte #(.DATA_W(8)) dut (
        .clk       (clk),
        .reset     (reset),
        .lane0_in  (lane0_in),
        .lane1_in  (lane1_in),
        .lane2_in  (lane2_in),
        .lane3_in  (lane3_in),
        .valid_in  (valid_in),
        .ready_out (ready_out),
        .data_out  (data_out),
        .valid_out (valid_out),
        .ready_in  (ready_in),
        .lane_err  (lane_err)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] obs,
                       input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic set_word(input logic [7:0] b0, input logic [7:0] b1,
                            input logic [7:0] b2, input logic [7:0] b3,
                            input logic [3:0] v);
        lane0_in = b0;
        lane1_in = b1;
        lane2_in = b2;
        lane3_in = b3;
        valid_in = v;
    endtask

    // One clock: compare outputs against the model, update, advance.
    task automatic tick();
        bit acc;
        bit bpop;
        bit wpop;
        chk("ready_out", {31'd0, ready_out}, {31'd0, mcount < 2});
        chk("valid_out", {31'd0, valid_out}, {31'd0, mcount != 0});
        chk("lane_err", {31'd0, lane_err}, {31'd0, merr});
        if (mcount == 0) chk("data_idle", {24'd0, data_out}, 32'd0);
        acc  = (valid_in == 4'hF) && (mcount < 2);
        bpop = (mcount != 0) && ready_in;
        wpop = bpop && (midx == 3);
        if (bpop) begin
            if (sb.size() == 0) begin
                chk("sb_underflow", 32'd1, 32'd0);
            end else begin
                chk("data_out", {24'd0, data_out}, {24'd0, sb[0]});
                void'(sb.pop_front());
            end
            midx = (midx + 1) % 4;
        end
        if (acc) begin
            sb.push_back(lane0_in);
            sb.push_back(lane1_in);
            sb.push_back(lane2_in);
            sb.push_back(lane3_in);
        end
`ifdef LANE_VALID_CHECK_EN
        if (valid_in != 4'h0 && valid_in != 4'hF) merr = 1'b1;
`endif
        mcount = mcount + (acc ? 1 : 0) - (wpop ? 1 : 0);
        @(posedge clk);
        #1;
    endtask

    task automatic model_reset();
        sb.delete();
        mcount = 0;
        midx = 0;
        merr = 1'b0;
    endtask

    initial begin
        #1;
        chk("rst_valid", {31'd0, valid_out}, 32'd0);
        chk("rst_ready", {31'd0, ready_out}, 32'd1);
        chk("rst_data", {24'd0, data_out}, 32'd0);
        chk("rst_err", {31'd0, lane_err}, 32'd0);
        @(negedge clk);
        @(negedge clk);
        reset = 1'b1;
        @(posedge clk);
        #1;

        // Single word, ready high
        ready_in = 1'b1;
        set_word(8'h11, 8'h22, 8'h33, 8'h44, 4'hF);
        tick();
        valid_in = 4'h0;
        repeat (6) tick();
        chk("t1_drained", sb.size(), 32'd0);

        // Three pushes while stalled
        ready_in = 1'b0;
        set_word(8'h01, 8'h02, 8'h03, 8'h04, 4'hF);
        tick();
        set_word(8'h05, 8'h06, 8'h07, 8'h08, 4'hF);
        tick();
        set_word(8'hE1, 8'hE2, 8'hE3, 8'hE4, 4'hF);
        tick();
        chk("t2_third_rej", sb.size(), 32'd8);
        valid_in = 4'h0;
        ready_in = 1'b1;
        repeat (10) tick();
        chk("t2_drained", sb.size(), 32'd0);

        // Ready toggling holds bytes
        ready_in = 1'b0;
        set_word(8'hA1, 8'hB2, 8'hC3, 8'hD4, 4'hF);
        tick();
        valid_in = 4'h0;
        for (int i = 0; i < 8; i++) begin
            ready_in = (i % 2 == 0);
            held = data_out;
            tick();
            if (i % 2 == 1) chk("t3_hold", {24'd0, data_out}, {24'd0, held});
        end
        ready_in = 1'b1;
        repeat (4) tick();
        chk("t3_drained", sb.size(), 32'd0);

        // Partial valid dropped
        set_word(8'h5A, 8'h5B, 8'h5C, 8'h5D, 4'b0110);
        tick();
        valid_in = 4'h0;
        tick();
        chk("t4_nopush", sb.size(), 32'd0);

        // Reset mid-word with two words buffered
        set_word(8'h31, 8'h32, 8'h33, 8'h34, 4'hF);
        ready_in = 1'b0;
        tick();
        set_word(8'h41, 8'h42, 8'h43, 8'h44, 4'hF);
        tick();
        valid_in = 4'h0;
        ready_in = 1'b1;
        tick();
        tick();
        ready_in = 1'b0;
        #2;
        reset = 1'b0;
        #1;
        chk("mr_valid", {31'd0, valid_out}, 32'd0);
        chk("mr_data", {24'd0, data_out}, 32'd0);
        chk("mr_ready", {31'd0, ready_out}, 32'd1);
        chk("mr_err", {31'd0, lane_err}, 32'd0);
        model_reset();
        @(negedge clk);
        reset = 1'b1;
        @(posedge clk);
        #1;
        ready_in = 1'b1;
        set_word(8'hA0, 8'hA1, 8'hA2, 8'hA3, 4'hF);
        tick();
        valid_in = 4'h0;
        repeat (5) tick();
        chk("mr_drained", sb.size(), 32'd0);

        // Push coinciding with word-pop at count 1
        set_word(8'h61, 8'h62, 8'h63, 8'h64, 4'hF);
        tick();
        valid_in = 4'h0;
        tick();
        tick();
        tick();
        set_word(8'h71, 8'h72, 8'h73, 8'h74, 4'hF);
        tick();
        valid_in = 4'h0;
        chk("t6_count1", {31'd0, valid_out}, 32'd1);
        chk("t6_lane0", {24'd0, data_out}, 32'h71);
        repeat (5) tick();
        chk("t6_drained", sb.size(), 32'd0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule

// File: doc/mux4to1_byte.md
# mux4to1_byte

Lane-to-byte merger for the PCIe physical-layer datapath: the receive-side counterpart of the 1:4 byte demux. It accepts one 4-lane parallel word (one byte per lane, per-lane valid) and re-serializes it onto a single 8-bit byte stream in lane order 0,1,2,3. A 2-entry word buffer and a ready/valid handshake on both sides absorb downstream stalls.

## Interface
- DATA_W, 8, bits per lane byte; the output byte width is the same.
- clk  in  1  single clock, all state on rising edge
- reset  in  1  asynchronous, active-low; 0 clears all state immediately
- lane0_in .. lane3_in  in  DATA_W each  lane bytes of the incoming word
- valid_in  in  4  per-lane valid, bit i qualifies lane i
- ready_out  out  1  block can accept a word this cycle
- data_out  out  DATA_W  serialized byte
- valid_out  out  1  data_out holds a valid byte
- ready_in  in  1  downstream accepts data_out this cycle
- lane_err  out  1  sticky lane-valid mismatch flag (see Configuration)

## Operation
- Push: at a clk edge with valid_in == 4'b1111 and ready_out == 1, the word {lane3,lane2,lane1,lane0} is written to the buffer tail.
- Partial valid (valid_in neither 0 nor 4'b1111): the word is dropped and never pushed.
- ready_out = (count < 2); combinational from registered count only.
- Buffer: 2 entries of 4*DATA_W, with wr_ptr, rd_ptr (1 bit each) and count (0..2).
- Serializer: byte index idx (2 bits). valid_out = (count != 0). data_out = head entry lane[idx] when count != 0, else 0.
- Pop byte: at an edge with valid_out && ready_in, idx increments. At idx == 3 it wraps to 0, rd_ptr toggles and count decrements.
- Simultaneous push and word-pop in one edge: count is unchanged and both pointers advance.
- Full (count == 2): ready_out = 0, so no push occurs, even if a word-pop happens in the same edge.
- Occupancy states: EMPTY (count 0), ONE (count 1), FULL (count 2).
  - EMPTY -> ONE on a push.
  - ONE -> FULL on a push without a word-pop.
  - ONE -> EMPTY on a word-pop without a push.
  - FULL -> ONE on a word-pop.
- No combinational path from any input to data_out, valid_out or ready_out.

## Timing
- Reset values: data_out = 0, valid_out = 0, ready_out = 1, lane_err = 0; count, idx and pointers = 0. The outputs take these values as soon as reset falls, without waiting for a clock edge.
- Reset asserted mid-word discards all buffered bytes. After release, the first push is accepted on the first clk edge.
- Latency: a word pushed at edge N presents lane0 on data_out after edge N. Each following byte follows one edge later per accepted transfer.
- Throughput: 1 byte per cycle with ready_in held high, i.e. 1 word per 4 cycles. The 2nd buffer entry lets upstream push during serialization.
- Holding ready_in low freezes data_out, idx and count.

## Configuration
- LANE_VALID_CHECK_EN defined: at any edge where valid_in is neither 4'b0000 nor 4'b1111, lane_err sets to 1 and stays 1 until reset.
- LANE_VALID_CHECK_EN undefined: lane_err is tied to 0. Partial words are still dropped silently.

## Structure
- Shared package mux_pkg holds:
  - LANES = 4
  - IDX_W = 2
  - BUF_DEPTH = 2
  - the all-valid constant 4'b1111
  - the occupancy state encoding (EMPTY/ONE/FULL)
- One sub-module, mux_word_fifo: the 2-entry, 4*DATA_W-wide buffer with push, pop, count, full and empty. The top level owns the serializer idx, the output select and the error logic.

## Test plan
- Reset then one word 0x11,0x22,0x33,0x44 pushed with ready_in = 1 -> data_out 0x11,0x22,0x33,0x44 on 4 consecutive cycles, valid_out high exactly 4 cycles, ready_out stays 1.
- Three words pushed back-to-back with ready_in = 0 -> ready_out falls after the 2nd push and the 3rd push is not accepted. Raise ready_in -> 8 bytes out in order, ready_out returns to 1 after the first word is drained.
- Push word A; toggle ready_in 1,0,1,0 -> data_out holds each byte while ready_in = 0 and no byte is skipped or duplicated.
- valid_in = 4'b0110 for one edge -> nothing is pushed and valid_out stays 0. lane_err = 1 with LANE_VALID_CHECK_EN defined, 0 without it.
- Assert reset while idx = 2 with 2 words buffered -> valid_out = 0, data_out = 0, ready_out = 1 without waiting for a clock edge. After release a new word 0xA0..0xA3 comes out intact.
- Word-pop and push in the same edge when count = 1 -> count stays 1 and the new word's lane0 appears on the cycle after the old lane3.
